spi_ram_arbiter: RTL
====================

# spi_ram_arbiter

Two-port round-robin arbiter and command sequencer for the SPI-slave RAM. It accepts whole byte read/write transactions from two requesters and serialises each into the RAM's 10-bit command protocol on `din`/`rx_valid`: `00`=write address, `01`=write data, `10`=read address, `11`=read. It captures `dout` when `tx_valid` is asserted and returns the byte to the winning requester. It sits between the on-chip masters and the RAM, in place of the SPI slave front end, and is the only driver of the RAM command port.

## Interface
- `TIMEOUT`, default 4: maximum cycles spent in RWAIT for `ram_tx_valid` before aborting; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0`, `req1` in 1: transaction request, level, held until the matching ack.
- `we0`, `we1` in 1: 1 = write, 0 = read; sampled with req.
- `addr0`, `addr1` in 8: byte address.
- `wdata0`, `wdata1` in 8: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse to the requester.
- `rdata` out 8: read data, valid with ack of a read; held until the next read completes.
- `err` out 1: pulses with ack when a read timed out.
- `busy` out 1: high in every state except IDLE.
- `ram_din` out 10: command word to the RAM.
- `ram_rx_valid` out 1: command valid.
- `ram_dout` in 8: RAM read data.
- `ram_tx_valid` in 1: RAM read-data valid.

## Operation
- States: IDLE, ADDR, WDATA, RCMD, RWAIT, DONE.
- IDLE: if any req is high, pick a winner by round-robin.
  - If only one requester asks, it wins.
  - If both ask, the one not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie.
  - Latch the winner index, we, addr and wdata; update the pointer; go to ADDR.
- ADDR: `ram_din={we?2'b00:2'b10, addr}`, `ram_rx_valid=1`. Next state is WDATA for a write, RCMD for a read.
- WDATA: `ram_din={2'b01, wdata}`, `ram_rx_valid=1`, then DONE.
- RCMD: `ram_din={2'b11, 8'h00}`, `ram_rx_valid=1`, then RWAIT; clear the timeout counter.
- RWAIT: `ram_rx_valid=0`.
  - If `ram_tx_valid`=1: `rdata<=ram_dout`, go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1: `rdata<=8'h00`, set the error flag, go to DONE.
  - Otherwise increment the counter.
- DONE: pulse the winner's ack; pulse `err` if flagged; clear the flag; go to IDLE.
- `ram_din` and `ram_rx_valid` decode from registered state and latched fields only; there is no combinational path from requester inputs.
- Outside ADDR/WDATA/RCMD: `ram_rx_valid=0` and `ram_din=10'h000`.
- `ram_tx_valid` outside RWAIT is ignored.
- Changes to req/we/addr/wdata after the winner is latched have no effect on the transaction in flight.
- The losing requester's req simply stays pending; it is never dropped.

## Timing
- Reset values (asynchronous): state IDLE, `ack0=ack1=0`, `err=0`, `rdata=8'h00`, `busy=0`, `ram_rx_valid=0`, `ram_din=10'h000`, pointer=1, counter=0.
- Write: req sampled at edge E0. ADDR in cycle 1, WDATA in cycle 2, DONE/ack in cycle 3, IDLE in cycle 4. Total 4 cycles from sample to the next possible sample.
- Read: ADDR in cycle 1, RCMD in cycle 2. The RAM raises `tx_valid` at the edge closing RCMD, so nominally RWAIT lasts 1 cycle, DONE is cycle 4 and IDLE cycle 5. Each extra wait cycle adds 1.
- The requester must drop req at the edge closing its ack cycle. A req still high in IDLE starts a new transaction.
- Timeout: RWAIT lasts exactly TIMEOUT cycles with no `tx_valid`, then DONE with `err=1`, `rdata=0`.
- `rst` mid-transaction: immediate return to reset values. No ack is issued, and the partial command sequence is abandoned.

## Test plan
- Write then read: req0 writes 8'hA5 to 8'h3C, then reads 8'h3C. The bus shows 10'h03C, 10'h1A5, ack0 in cycle 3, then 10'h23C, 10'h300. ack0 arrives with `rdata=8'hA5`, `err=0`.
- Simultaneous: req0 and req1 both write from reset. Requester 0 is served first, then requester 1. With both held continuously, service alternates 0,1,0,1 and acks are spaced 4 cycles apart.
- Single requester streaming: req1 alone performs 3 back-to-back writes. Each is acked and req0's pointer state never blocks it.
- Timeout: `ram_tx_valid` tied 0, TIMEOUT=4, read request. RWAIT lasts 4 cycles, then ack with `err=1` and `rdata=8'h00`; the next transaction runs normally.
- Reset mid-read: assert `rst` during RCMD. `ram_rx_valid` and `busy` go 0 immediately and no ack is issued. After release, a pending req0 starts at ADDR.
- Late/spurious `tx_valid`: pulse `ram_tx_valid` in IDLE and during a write. There is no effect on `rdata`, ack or state.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter for two byte requesters in front of the SPI-slave RAM.
// Serialises each transaction into the RAM's 10-bit command words.
module spi_ram_arbiter #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  output logic [9:0] ram_din,
  output logic       ram_rx_valid,
  input  logic [7:0] ram_dout,
  input  logic       ram_tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RCMD,
    RWAIT,
    DONE
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t     state;
  logic       win;
  logic       last;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] cnt;

  logic       pick;
  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;

  // On a tie the requester not served last wins.
  always_comb begin
    pick      = (req0 && req1) ? ~last : req1;
    sel_we    = pick ? we1 : we0;
    sel_addr  = pick ? addr1 : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      win          <= 1'b0;
      last         <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      cnt          <= 8'h00;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err          <= 1'b0;
      rdata        <= 8'h00;
      busy         <= 1'b0;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
    end else begin
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      err          <= 1'b0;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            win          <= pick;
            last         <= pick;
            we_q         <= sel_we;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            busy         <= 1'b1;
            ram_din      <= {(sel_we ? 2'b00 : 2'b10), sel_addr};
            ram_rx_valid <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          ram_rx_valid <= 1'b1;
          if (we_q) begin
            ram_din <= {2'b01, wdata_q};
            state   <= WDATA;
          end else begin
            ram_din <= {2'b11, 8'h00};
            state   <= RCMD;
          end
        end
        WDATA: begin
          ack0  <= ~win;
          ack1  <= win;
          state <= DONE;
        end
        RCMD: begin
          cnt   <= 8'h00;
          state <= RWAIT;
        end
        RWAIT: begin
          if (ram_tx_valid) begin
            rdata <= ram_dout;
            ack0  <= ~win;
            ack1  <= win;
            state <= DONE;
          end else if (cnt == TMAX) begin
            rdata <= 8'h00;
            err   <= 1'b1;
            ack0  <= ~win;
            ack1  <= win;
            state <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
